// File: rtl/dmm_pkg.sv
// Shared types and helpers for the burst data memory.
package dmm_pkg;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, XFER} state_t;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Parameter legality: byte-multiple width, power-of-two depth/burst, latency >= 1.
  function automatic bit params_ok(input int unsigned width, input int unsigned depth,
                                   input int unsigned addr_size, input int unsigned latency,
                                   input int unsigned burst);
    return (width != 0) && ((width % 8) == 0) && is_pow2(depth) &&
           ((32'd1 << addr_size) == depth) && (latency >= 1) &&
           is_pow2(burst) && (burst <= depth);
  endfunction

  // Word address of beat k in a burst that wraps inside its aligned block.
  function automatic int unsigned beat_addr(input int unsigned base, input int unsigned k,
                                            input int unsigned burst);
    return (base & ~(burst - 1)) | ((base + k) & (burst - 1));
  endfunction

endpackage

// File: rtl/dmm_burst_if.sv
// Request/response bus between the cache controller and the burst memory.
interface dmm_burst_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_SIZE = 10
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [ADDR_SIZE-1:0]   req_addr;
  logic [WIDTH/8-1:0]     req_be;
  logic [WIDTH-1:0]       req_wdata;
  logic                   rsp_valid;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_last;
  logic                   wr_done;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_last, wr_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_last, wr_done
  );
endinterface

// File: rtl/dmm_array.sv
// Single-port storage: byte-enable write, synchronous read that holds when idle.
module dmm_array #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WIDTH/8-1:0]   be,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);
  localparam int unsigned NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  // Byte-masked write; contents are cleared by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register only loads on a read so the last beat stays visible.
  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dmm_burst.sv
// Latency-programmable data memory with wrapped critical-word-first read bursts.
module dmm_burst
  import dmm_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned BURST     = 4
) (
  input  logic       clk,
  input  logic       rst,
  dmm_burst_if.slave bus
);
  localparam int unsigned NB     = WIDTH / 8;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

  if (!params_ok(WIDTH, DEPTH, ADDR_SIZE, LATENCY, BURST)) begin : g_param_err
    $error("dmm_burst: illegal parameter set");
  end

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [ADDR_SIZE-1:0] clr_q, clr_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [NB-1:0]        be_q, be_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_last_q, rsp_last_d;
  logic                 wr_done_q, wr_done_d;

  logic                 mem_we, mem_re;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [NB-1:0]        mem_be;
  logic [WIDTH-1:0]     mem_wdata, mem_rdata;

  // State, counters, latched request and response flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      beat_q      <= '0;
      clr_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      clr_q       <= clr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      wr_done_q   <= wr_done_d;
    end
  end

  // Next state plus the memory port mux shared by the clear sweep and accesses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    clr_d       = clr_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    wr_done_d   = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = addr_q;
    mem_be      = be_q;
    mem_wdata   = wdata_q;

    unique case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_addr  = clr_q;
        mem_be    = '1;
        mem_wdata = '0;
        clr_d     = clr_q + ADDR_SIZE'(1);
        if (clr_q == ADDR_SIZE'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          be_d    = bus.req_be;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (we_q) begin
          mem_we    = 1'b1;
          wr_done_d = 1'b1;
          state_d   = IDLE;
        end else begin
          mem_re      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_last_d  = (BURST == 32'd1);
          beat_d      = BEAT_W'(1);
          state_d     = (BURST == 32'd1) ? IDLE : XFER;
        end
      end
      XFER: begin
        mem_re      = 1'b1;
        mem_addr    = ADDR_SIZE'(beat_addr(32'(addr_q), 32'(beat_q), BURST));
        rsp_valid_d = 1'b1;
        beat_d      = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(BURST - 1)) begin
          rsp_last_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // A write scheduled for the reset edge must not commit.
  dmm_array #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we & rst),
    .re   (mem_re),
    .addr (mem_addr),
    .be   (mem_be),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = mem_rdata;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.wr_done   = wr_done_q;
endmodule

// File: tb/tb_dmm_burst.sv
// Scoreboard bench for dmm_burst with a word-array reference model.
module tb_dmm_burst;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned ADDR_SIZE = 10;
  localparam int unsigned LATENCY   = 4;
  localparam int unsigned BURST     = 4;

  typedef struct {
    logic [31:0] data;
    bit          last;
    int          cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  beat_t       rq[$];
  int          wq[$];
  logic [31:0] model [DEPTH];
  beat_t       mon_e;
  int          mon_w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmm_burst_if #(.WIDTH(WIDTH), .ADDR_SIZE(ADDR_SIZE)) bus ();

  dmm_burst #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_SIZE(ADDR_SIZE),
    .LATENCY(LATENCY), .BURST(BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Wrapped burst address computed from block base and offset.
  function automatic int ref_addr(input int a, input int k);
    return (a / int'(BURST)) * int'(BURST) + (a + k) % int'(BURST);
  endfunction

  // Monitor: every beat and every write pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.rsp_valid) begin
        if (rq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rsp_unexpected: got beat %h, required none (cycle %0d)", bus.rsp_data, cyc);
        end else begin
          mon_e = rq.pop_front();
          chk("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
          chk("rsp_last", 64'(bus.rsp_last), 64'(mon_e.last));
          chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else if (bus.rsp_last) begin
        chk("rsp_last_idle", 64'(bus.rsp_last), 64'(0));
      end
      if (bus.wr_done) begin
        if (wq.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL wr_done_unexpected: got pulse, required none (cycle %0d)", cyc);
        end else begin
          mon_w = wq.pop_front();
          chk("wr_done_cycle", 64'(cyc), 64'(mon_w));
        end
      end
    end
  end

  // Present a request, wait for acceptance, record expectations from the model.
  task automatic issue(input bit we, input int a, input logic [3:0] be,
                       input logic [31:0] d, input bit track, output int c0);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = 10'(a);
    bus.req_be    = be;
    bus.req_wdata = d;
    while (bus.req_ready !== 1'b1) begin
      guard++;
      if (guard > 3000) begin
        n_cmp++; n_fail++;
        $display("FAIL req_ready_timeout: got ready=%b, required 1 within 3000 cycles", bus.req_ready);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "request never accepted");
      end
      @(negedge clk);
    end
    c0 = cyc + 1;
    if (track) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
        wq.push_back(c0 + int'(LATENCY));
      end else begin
        for (int k = 0; k < int'(BURST); k++)
          rq.push_back('{model[ref_addr(a, k)], (k == int'(BURST) - 1), c0 + int'(LATENCY) + k});
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = 10'($urandom);
    bus.req_be    = 4'($urandom);
    bus.req_wdata = $urandom;
  endtask

  // Called at the negedge right after rst is released: cycles until ready.
  task automatic sweep_len(output int n);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset_flush();
    rq.delete();
    wq.delete();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
  endtask

  int c0, c1, c2, n;
  int guard;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;
    do_reset_flush();

    // Reset held for three edges, then the clear sweep.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_rsp_data", 64'(bus.rsp_data), 64'(0));
    chk("reset_rsp_last", 64'(bus.rsp_last), 64'(0));
    chk("reset_wr_done", 64'(bus.wr_done), 64'(0));
    chk("reset_req_ready", 64'(bus.req_ready), 64'(0));
    rst = 1'b1;
    sweep_len(n);
    chk("sweep_len", 64'(n), 64'(DEPTH));

    // Top block reads back zero after the sweep.
    issue(1'b0, 'h3FF, 4'h0, 32'h0, 1'b1, c0);

    // Full write then read: data plus zeros in the rest of the block.
    issue(1'b1, 'h010, 4'hF, 32'hDEADBEEF, 1'b1, c0);
    issue(1'b0, 'h010, 4'h0, 32'h0, 1'b1, c0);

    // Partial byte enables, and a write with no enables at all.
    issue(1'b1, 'h020, 4'hF, 32'h11223344, 1'b1, c0);
    issue(1'b1, 'h020, 4'b0101, 32'hAABBCCDD, 1'b1, c0);
    issue(1'b1, 'h021, 4'h0, 32'hFFFFFFFF, 1'b1, c0);
    issue(1'b0, 'h020, 4'h0, 32'h0, 1'b1, c0);

    // Wrapped burst starting mid-block.
    for (int i = 0; i < 4; i++) issue(1'b1, 'h40 + i, 4'hF, 32'hA0 + 32'(i), 1'b1, c0);
    issue(1'b0, 'h042, 4'h0, 32'h0, 1'b1, c0);

    // Back-to-back: second read accepted in the cycle showing the last beat.
    issue(1'b0, 'h041, 4'h0, 32'h0, 1'b1, c1);
    issue(1'b0, 'h043, 4'h0, 32'h0, 1'b1, c2);
    chk("b2b_read_accept", 64'(c2), 64'(c1 + int'(LATENCY) + int'(BURST)));
    issue(1'b1, 'h043, 4'hF, 32'h5A5A5A5A, 1'b1, c1);
    issue(1'b0, 'h043, 4'h0, 32'h0, 1'b1, c2);
    chk("b2b_write_accept", 64'(c2), 64'(c1 + int'(LATENCY) + 1));

    // Randomized traffic over a few blocks, including the top one.
    for (int i = 0; i < 80; i++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? 'h3F8 + int'($urandom_range(0, 7))
                                      : 'h100 + int'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, 1'b1, c0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset during the second beat of a burst.
    issue(1'b0, 'h100, 4'h0, 32'h0, 1'b1, c0);
    guard = 0;
    while (cyc != c0 + int'(LATENCY) + 1 && guard < 100) begin guard++; @(negedge clk); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midburst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("midburst_rsp_last", 64'(bus.rsp_last), 64'(0));
    do_reset_flush();
    @(negedge clk);
    rst = 1'b1;
    sweep_len(n);
    chk("sweep_len_after_abort", 64'(n), 64'(DEPTH));
    issue(1'b0, 'h100, 4'h0, 32'h0, 1'b1, c0);

    // Write aborted by reset while waiting: no pulse, word stays zero.
    issue(1'b1, 'h060, 4'hF, 32'h12345678, 1'b0, c0);
    guard = 0;
    while (cyc != c0 + 2 && guard < 100) begin guard++; @(negedge clk); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wr_done", 64'(bus.wr_done), 64'(0));
    do_reset_flush();
    @(negedge clk);
    rst = 1'b1;
    sweep_len(n);
    chk("sweep_len_after_wr_abort", 64'(n), 64'(DEPTH));
    issue(1'b0, 'h060, 4'h0, 32'h0, 1'b1, c0);

    // Drain outstanding expectations.
    guard = 0;
    while ((rq.size() != 0 || wq.size() != 0) && guard < 200) begin guard++; @(negedge clk); end
    @(negedge clk);
    chk("queues_drained", 64'(rq.size() + wq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
